exec_sequencer: RTL
===================

# exec_sequencer

Multi-cycle control sequencer for the core datapath: program BRAM, register file and ALU. The BRAM has a one-cycle synchronous read, so the core cannot fetch, execute and write back in one clock. This block owns the PC and sequences each instruction through fetch, memory wait, execute and writeback. It latches the instruction word and drives the register-file write enable, the ALU operand select and the writeback select.

## Interface
Parameters:
- PC_LIMIT, 32'h0000_00FC — last valid instruction address; the PC wraps to 0 after executing it.
- OP_ITYPE, 7'b0010011 — I-type ALU opcode.
- OP_RTYPE, 7'b0110011 — R-type ALU opcode.
- OP_JAL, 7'b1101111 — jump-and-link opcode.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  level; permits execution.
- halt_req  in  1  stop request, sampled in WB only.
- instr  in  32  BRAM douta.
- rom_addr  out  32  BRAM addra; always equals pc.
- pc  out  32  current instruction address.
- ir  out  32  latched instruction word.
- alu_src  out  1  1 = immediate operand (ir opcode == OP_ITYPE).
- wb_sel_pc  out  1  1 = writeback data is pc+4 (JAL); 0 = ALU result.
- rf_we  out  1  register-file write enable, one-cycle pulse in WB.
- retire  out  1  one-cycle pulse in WB for every completed instruction.
- illegal  out  1  one-cycle pulse in WB when the opcode is not one of the three above.
- busy  out  1  high in any state other than IDLE.
- instr_count  out  32  number of retired instructions, wraps mod 2^32.

## Operation
States are IDLE, FETCH, MEM, EXEC and WB. Encoding is free; none is exported.

State transitions:
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH: rom_addr=pc; the BRAM captures the address at this edge. Go to MEM.
- MEM: instr is valid; ir <= instr at the end of the cycle. Go to EXEC.
- EXEC: decode outputs alu_src and wb_sel_pc are driven from ir; the ALU settles. Go to WB.
- WB: side effects and exit are below.

WB side effects:
- rf_we=1 if opcode is ITYPE, RTYPE or JAL and rd (ir[11:7]) != 0.
- retire=1 and instr_count++.
- illegal=1 for any other opcode, which is otherwise treated as a NOP (no write, pc+4).

WB exit:
- Go to IDLE if halt_req=1 or run=0.
- Otherwise go to FETCH.

PC update happens only at the end of WB, with this priority:
1. pc == PC_LIMIT: pc <= 0, even for JAL.
2. JAL: pc <= pc + {{10{ir[31]}}, ir[31:12], 2'b00}, modulo 2^32. The 20-bit word offset is sign-extended and scaled by 4.
3. Otherwise: pc <= pc + 4.

Other rules:
- alu_src and wb_sel_pc are combinational from ir and are valid in every state; they are meaningful in EXEC and WB.
- run dropping mid-instruction does not abort: the instruction completes and the block returns to IDLE after WB.
- halt_req outside WB is ignored.

## Timing
- Reset values: state=IDLE, pc=0, ir=0, instr_count=0, rf_we=0, retire=0, illegal=0, busy=0. rom_addr=0, alu_src=0, wb_sel_pc=0.
- Reset in any state abandons the instruction in flight: no rf_we, no retire and no PC change. rst=1 together with run=1 leaves the block in IDLE.
- Each instruction takes 4 cycles (FETCH, MEM, EXEC, WB). Throughput with continuous run is 1 instruction per 4 clocks.
- First FETCH is one cycle after run is sampled high in IDLE.
- rf_we, retire and illegal are registered-state decodes, asserted exactly during the WB cycle. The register file writes on the rising edge that ends WB.
- New pc is visible on rom_addr in the cycle after WB (FETCH, or IDLE when halting).
- instr_count increments on the edge ending WB; it wraps from FFFF_FFFF to 0.

## Test plan
- Reset, then run=1 with ROM[0]=addi x1,x0,5 (0x00500093): ir=0x00500093 in EXEC; WB cycle has rf_we=1, alu_src=1, wb_sel_pc=0, retire=1; pc=4 at next FETCH; instr_count=1.
- JAL with ir[31:12]=20'h00003 at pc=8: rf_we=1 and wb_sel_pc=1 in WB; next pc=0x14. With offset 20'hFFFFF at pc=8: next pc=4.
- pc reaches PC_LIMIT=0xFC holding a JAL: next pc=0 (wrap wins); pc increments in steps of 4 with exactly 4 cycles between retire pulses.
- Opcode 7'b0000011 at pc=0x10: illegal=1 and retire=1 in WB, rf_we=0, next pc=0x14. With rd=0 on an R-type: rf_we=0 and retire=1.
- halt_req pulsed in EXEC only: ignored. halt_req=1 in WB: IDLE next cycle, busy=0, pc advanced. run low during MEM: the instruction retires, then IDLE.
- rst asserted during EXEC: next cycle state=IDLE, pc=0, ir=0, instr_count=0; no rf_we or retire pulse occurs.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control sequencer for the core datapath.
// Owns the PC and walks each instruction through FETCH, MEM, EXEC and WB,
// because the program BRAM returns data one cycle after the address edge.
// Latches the instruction word and produces the register-file write enable,
// ALU operand select and writeback select for the rest of the core.
module exec_sequencer #(
    parameter logic [31:0] PC_LIMIT = 32'h0000_00FC,
    parameter logic [6:0]  OP_ITYPE = 7'b0010011,
    parameter logic [6:0]  OP_RTYPE = 7'b0110011,
    parameter logic [6:0]  OP_JAL   = 7'b1101111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt_req,
    input  logic [31:0] instr,
    output logic [31:0] rom_addr,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        alu_src,
    output logic        wb_sel_pc,
    output logic        rf_we,
    output logic        retire,
    output logic        illegal,
    output logic        busy,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEM,
        S_EXEC,
        S_WB
    } state_t;

    state_t     state;
    logic [6:0] opcode;
    logic [4:0] rd;

    // Opcode and destination fields of the latched instruction.
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];

    // True for the three opcodes this core executes; anything else is a NOP.
    function automatic logic op_is_legal(input logic [6:0] op);
        return (op == OP_ITYPE) || (op == OP_RTYPE) || (op == OP_JAL);
    endfunction

    // PC after the current instruction: the wrap at PC_LIMIT overrides even a
    // JAL, then the JAL target, then sequential fall-through.
    function automatic logic [31:0] next_pc(input logic [31:0] cur_pc,
                                            input logic [31:0] iw);
        logic signed [31:0] jal_off;
        jal_off = {{10{iw[31]}}, iw[31:12], 2'b00};
        if (cur_pc == PC_LIMIT) begin
            return 32'd0;
        end else if (iw[6:0] == OP_JAL) begin
            return cur_pc + $unsigned(jal_off);
        end else begin
            return cur_pc + 32'd4;
        end
    endfunction

    // The BRAM address is the PC itself; decode selects follow ir in every state.
    assign rom_addr  = pc;
    assign alu_src   = (opcode == OP_ITYPE);
    assign wb_sel_pc = (opcode == OP_JAL);

    // Sequencer FSM: state, PC, instruction latch, retire counter and the
    // WB-cycle pulses, all registered. The pulses are loaded on the edge that
    // enters WB so they are high exactly for the WB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= 32'd0;
            ir          <= 32'd0;
            instr_count <= 32'd0;
            rf_we       <= 1'b0;
            retire      <= 1'b0;
            illegal     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            retire  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // BRAM captures rom_addr at this edge; data arrives in MEM.
                    state <= S_MEM;
                end
                S_MEM: begin
                    ir    <= instr;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    rf_we   <= op_is_legal(opcode) && (rd != 5'd0);
                    retire  <= 1'b1;
                    illegal <= !op_is_legal(opcode);
                    state   <= S_WB;
                end
                S_WB: begin
                    instr_count <= instr_count + 32'd1;
                    pc          <= next_pc(pc, ir);
                    if (halt_req || !run) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
